preamble_serializer_101: RTL and testbench
==========================================

# preamble_serializer_101

Parallel-to-serial transmitter that frames each DATA_W-bit word with a fixed `101` preamble and shifts it out one bit per clock, MSB first, on a single serial line. It is the transmit end of the serial `101`-framed link: its `x_out` drives the `x` input of the downstream Moore `101` sequence detector. Upstream logic hands it words through a single-cycle load/ready handshake.

## Interface
- `DATA_W`, default 8: payload width in bits; legal range is 2 to 32.
- `clk`  input  1: single clock; all logic is on the rising edge.
- `reset_n`  input  1: synchronous reset, active-low, sampled on the rising edge of `clk`.
- `load`  input  1: upstream offers `data_in`; the word is accepted when `load && ready` at a rising edge.
- `data_in`  input  DATA_W: payload word, sampled only on the accepting edge.
- `ready`  output  1: high when the block can accept a word (IDLE or GAP).
- `x_out`  output  1: serial line carrying the preamble, then the payload MSB first; idles at 0.
- `frame_active`  output  1: high while the preamble or payload is on `x_out`.
- `done`  output  1: one-cycle pulse in the GAP cycle after the last payload bit.

## Operation
- Moore FSM. All outputs are decoded from the present state, the shift-register MSB and the bit counter. No output depends combinationally on `load` or `data_in`.
- States and outputs:
  - IDLE: x_out=0, ready=1, frame_active=0, done=0.
  - PRE1: x_out=1, frame_active=1.
  - PRE0: x_out=0, frame_active=1.
  - PRE2: x_out=1, frame_active=1.
  - DATA: x_out=shreg[DATA_W-1], frame_active=1.
  - GAP: x_out=0, ready=1, done=1.
- Transitions:
  - IDLE→PRE1 on `load`; otherwise stay in IDLE.
  - PRE1→PRE0→PRE2→DATA unconditionally.
  - DATA→DATA while bit_cnt < DATA_W-1. DATA→GAP when bit_cnt == DATA_W-1.
  - GAP→PRE1 on `load`; otherwise GAP→IDLE.
- On the accepting edge: shreg ← data_in and bit_cnt ← 0.
- In DATA, each edge does shreg ← {shreg[DATA_W-2:0], 1'b0} and bit_cnt ← bit_cnt+1.
- bit_cnt is $clog2(DATA_W) bits wide and never wraps past DATA_W-1.
- `load` is ignored while ready=0. A held `load` does not latch a pending request.
- Payload bits are not escaped. A `101` inside the payload is legal, and disambiguating it is the receiver's responsibility.
- Reset (reset_n=0 at an edge), from any state including mid-frame:
  - state ← IDLE, shreg ← 0, bit_cnt ← 0.
  - In the following cycle: x_out=0, frame_active=0, done=0, ready=1.
  - A `load` on the same edge as reset is dropped.

## Timing
- Reset values of outputs: ready=1, x_out=0, frame_active=0, done=0.
- Accept at edge k puts the first preamble bit (1) on x_out in cycle k+1.
- The payload MSB appears in cycle k+4 and the LSB in cycle k+3+DATA_W.
- frame_active stays high for exactly DATA_W+3 cycles. done is high in cycle k+4+DATA_W.
- The GAP cycle is always emitted, so the serial line gets at least one 0 between frames.
- Back-to-back throughput is one word per DATA_W+4 cycles, with load asserted during GAP.
- From IDLE, the frame-to-frame period is at least DATA_W+5 cycles.
- ready is low from cycle k+1 through k+3+DATA_W inclusive.

## Structure
- A shared package `ser101_pkg` holds:
  - the state enum (3-bit: IDLE, PRE1, PRE0, PRE2, DATA, GAP);
  - the constant `PREAMBLE = 3'b101`;
  - a function for the bit_cnt width.
- Sub-module `piso_shift_reg`: a DATA_W-bit parallel-load, left-shift register with `load_en`, `shift_en` and synchronous active-low clear. It exposes `msb`.
- The top level holds the FSM, the bit counter and the output decode.

## Test plan
- DATA_W=8. After reset, pulse load with data_in=8'hA5.
  - From the next cycle, x_out must be 1,0,1,1,0,1,0,0,1,0,1 then 0 in GAP.
  - frame_active must be high for 11 cycles, done high for 1 cycle, and ready back to 1 with done.
- load=1 held continuously with data_in=8'h00 then 8'hFF.
  - Frames must be back-to-back every 12 cycles: 101+00000000+0, then 101+11111111+0.
  - No extra IDLE cycles between them.
- load pulsed during PRE0 and again mid-DATA of an 8'h3C frame.
  - Both must be ignored; the frame completes unchanged and exactly one done pulse occurs.
- reset_n=0 at the 3rd payload bit of 8'hF0.
  - Next cycle: x_out=0, frame_active=0, ready=1.
  - A fresh load of 8'h81 must then yield 1,0,1,1,0,0,0,0,0,0,1.
- Loopback into the `101` detector, DATA_W=4, data_in=4'h0.
  - The detector output must assert exactly once per frame, in the cycle after PRE2 is sampled.
- DATA_W=2 build with data_in=2'b10.
  - x_out must be 1,0,1,1,0,0. bit_cnt must not overflow, and done must occur on the 6th cycle after accept.

Source files
------------

// File: rtl/ser101_pkg.sv
// ser101_pkg: shared state encoding, preamble constant and counter sizing for the 101-framed link
package ser101_pkg;
  typedef enum logic [2:0] {IDLE, PRE1, PRE0, PRE2, DATA, GAP} state_e;
  localparam logic [2:0] PREAMBLE = 3'b101;
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/preamble_serializer_101_if.sv
// preamble_serializer_101_if: word handshake and serial line bundle between upstream and serializer
interface preamble_serializer_101_if #(parameter int DATA_W = 8);
  logic load;
  logic [DATA_W-1:0] data_in;
  logic ready;
  logic x_out;
  logic frame_active;
  logic done;
  modport master (output load, data_in, input ready, x_out, frame_active, done);
  modport slave (input load, data_in, output ready, x_out, frame_active, done);
endinterface

// File: rtl/piso_shift_reg.sv
// piso_shift_reg: parallel-load, MSB-first left-shift register with synchronous clear
module piso_shift_reg #(parameter int DATA_W = 8) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              load_en,
  input  logic              shift_en,
  input  logic [DATA_W-1:0] d_i,
  output logic              msb
);
  logic [DATA_W-1:0] shreg_q, shreg_d;
  // load wins over shift so an accepting edge always captures the new word
  always_comb shreg_d = load_en ? d_i : shift_en ? {shreg_q[DATA_W-2:0], 1'b0} : shreg_q;
  // clear has priority over everything, including a coincident load
  always_ff @(posedge clk) shreg_q <= !clr_n ? '0 : shreg_d;
  assign msb = shreg_q[DATA_W-1];
endmodule

// File: rtl/preamble_serializer_101.sv
// preamble_serializer_101: frames each word with a 101 preamble and shifts it out MSB first
module preamble_serializer_101 #(parameter int DATA_W = 8) (
  input logic clk,
  input logic reset_n,
  preamble_serializer_101_if.slave bus
);
  import ser101_pkg::*;
  localparam int CW = cnt_w(DATA_W);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic rdy, accept, shift_en, last, msb;
  assign rdy = (state_q == IDLE) || (state_q == GAP);
  assign accept = bus.load && rdy;
  assign shift_en = state_q == DATA;
  assign last = cnt_q == CW'(DATA_W - 1);
  piso_shift_reg #(.DATA_W(DATA_W)) u_shreg (
    .clk(clk),
    .clr_n(reset_n),
    .load_en(accept),
    .shift_en(shift_en),
    .d_i(bus.data_in),
    .msb(msb)
  );
  // next state: preamble runs unconditionally, GAP either restarts or falls back to IDLE
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE: state_d = accept ? PRE1 : IDLE;
      PRE1: state_d = PRE0;
      PRE0: state_d = PRE2;
      PRE2: state_d = DATA;
      DATA: state_d = last ? GAP : DATA;
      GAP:  state_d = accept ? PRE1 : IDLE;
      default: state_d = IDLE;
    endcase
  end
  // bit counter saturates at the last payload bit so it never wraps
  always_comb cnt_d = accept ? '0 : (shift_en && !last) ? cnt_q + 1'b1 : cnt_q;
  // state and counter registers; a load on the reset edge is dropped
  always_ff @(posedge clk) begin
    state_q <= !reset_n ? IDLE : state_d;
    cnt_q <= !reset_n ? '0 : cnt_d;
  end
  assign bus.ready = rdy;
  assign bus.x_out = (state_q == PRE1) ? PREAMBLE[2] :
                     (state_q == PRE0) ? PREAMBLE[1] :
                     (state_q == PRE2) ? PREAMBLE[0] :
                     (state_q == DATA) ? msb : 1'b0;
  assign bus.frame_active = (state_q == PRE1) || (state_q == PRE0) || (state_q == PRE2) || (state_q == DATA);
  assign bus.done = state_q == GAP;
endmodule

// File: tb/tb_preamble_serializer_101.sv
// tb_preamble_serializer_101: drives 8/4/2-bit serializers in parallel against a frame-position model
module tb_preamble_serializer_101;
  import ser101_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n, load;
  logic [31:0] din;
  int checks = 0, errors = 0;
  int wid [3] = '{8, 4, 2};
  int pos [3] = '{0, 0, 0};
  logic [31:0] word [3];
  logic [2:0] det = 3'b000;
  logic [3:0] obs [3];
  preamble_serializer_101_if #(.DATA_W(8)) if8();
  preamble_serializer_101_if #(.DATA_W(4)) if4();
  preamble_serializer_101_if #(.DATA_W(2)) if2();
  assign if8.load = load;
  assign if4.load = load;
  assign if2.load = load;
  assign if8.data_in = din[7:0];
  assign if4.data_in = din[3:0];
  assign if2.data_in = din[1:0];
  preamble_serializer_101 #(.DATA_W(8)) dut8 (.clk(clk), .reset_n(reset_n), .bus(if8));
  preamble_serializer_101 #(.DATA_W(4)) dut4 (.clk(clk), .reset_n(reset_n), .bus(if4));
  preamble_serializer_101 #(.DATA_W(2)) dut2 (.clk(clk), .reset_n(reset_n), .bus(if2));
  assign obs[0] = {if8.ready, if8.x_out, if8.frame_active, if8.done};
  assign obs[1] = {if4.ready, if4.x_out, if4.frame_active, if4.done};
  assign obs[2] = {if2.ready, if2.x_out, if2.frame_active, if2.done};

  // expected {ready, x_out, frame_active, done} at position p of a frame (0 = idle, w+4 = gap)
  function automatic logic [3:0] exp_out(input int p, input int w, input logic [31:0] wd);
    logic [2:0] pre;
    pre = PREAMBLE;
    if (p == 0) return 4'b1000;
    if (p == w + 4) return 4'b1001;
    return {1'b0, (p <= 3) ? pre[3-p] : wd[w+3-p], 2'b10};
  endfunction

  task automatic step(input logic l, input logic [31:0] d, input logic rn);
    logic xp;
    load = l;
    din = d;
    reset_n = rn;
    xp = if4.x_out;
    @(posedge clk);
    det = {det[1:0], xp};
    for (int i = 0; i < 3; i++) begin
      if (!rn) pos[i] = 0;
      else if (l && (pos[i] == 0 || pos[i] == wid[i] + 4)) begin pos[i] = 1; word[i] = d; end
      else if (pos[i] == wid[i] + 4) pos[i] = 0;
      else if (pos[i] > 0) pos[i]++;
    end
    #1;
  endtask

  task automatic drain();
    for (int c = 0; c < 14; c++) step(1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_reset();
    step(1'b1, 32'h5A, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs[i] !== 4'b1000) begin errors++; $display("FAIL reset w=%0d got %b exp 1000", wid[i], obs[i]); end
    end
  endtask

  task automatic test_a5();
    logic [11:0] seq;
    int fa, dn;
    seq = 12'b101101001010;
    fa = 0;
    dn = 0;
    step(1'b1, 32'hA5, 1'b1);
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== exp_out(pos[i], wid[i], word[i])) begin errors++; $display("FAIL a5 w=%0d c=%0d got %b exp %b", wid[i], c, obs[i], exp_out(pos[i], wid[i], word[i])); end
      end
      checks++;
      if (if8.x_out !== seq[11-c]) begin errors++; $display("FAIL a5_x c=%0d got %b exp %b", c, if8.x_out, seq[11-c]); end
      if (c == 11) begin
        checks++;
        if ({if8.ready, if8.done} !== 2'b11) begin errors++; $display("FAIL a5_gap got %b exp 11", {if8.ready, if8.done}); end
      end
      fa += int'(if8.frame_active);
      dn += int'(if8.done);
      step(1'b0, 32'h0, 1'b1);
    end
    checks++;
    if (fa != 11 || dn != 1) begin errors++; $display("FAIL a5_counts got fa=%0d done=%0d exp fa=11 done=1", fa, dn); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] seq;
    seq = 24'b101000000000_101111111110;
    drain();
    step(1'b1, 32'h00, 1'b1);
    for (int c = 0; c < 24; c++) begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== exp_out(pos[i], wid[i], word[i])) begin errors++; $display("FAIL b2b w=%0d c=%0d got %b exp %b", wid[i], c, obs[i], exp_out(pos[i], wid[i], word[i])); end
      end
      checks++;
      if (if8.x_out !== seq[23-c]) begin errors++; $display("FAIL b2b_x c=%0d got %b exp %b", c, if8.x_out, seq[23-c]); end
      step(c < 23, 32'hFF, 1'b1);
    end
  endtask

  task automatic test_ignore_busy_load();
    logic [11:0] seq;
    int dn;
    seq = 12'b101001111000;
    dn = 0;
    drain();
    step(1'b1, 32'h3C, 1'b1);
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== exp_out(pos[i], wid[i], word[i])) begin errors++; $display("FAIL ignore w=%0d c=%0d got %b exp %b", wid[i], c, obs[i], exp_out(pos[i], wid[i], word[i])); end
      end
      checks++;
      if (if8.x_out !== seq[11-c]) begin errors++; $display("FAIL ignore_x c=%0d got %b exp %b", c, if8.x_out, seq[11-c]); end
      dn += int'(if8.done);
      step(c == 1 || c == 6, 32'hFF, 1'b1);
    end
    checks++;
    if (dn != 1) begin errors++; $display("FAIL ignore_done got %0d exp 1", dn); end
  endtask

  task automatic test_reset_mid_frame();
    logic [11:0] seq;
    seq = 12'b101100000010;
    drain();
    step(1'b1, 32'hF0, 1'b1);
    for (int c = 0; c < 5; c++) step(1'b0, 32'h0, 1'b1);
    checks++;
    if ({if8.x_out, if8.frame_active} !== 2'b11) begin errors++; $display("FAIL rstmid_pre got %b exp 11", {if8.x_out, if8.frame_active}); end
    step(1'b1, 32'hF0, 1'b0);
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (obs[0] !== 4'b1000) begin errors++; $display("FAIL rstmid_idle c=%0d got %b exp 1000", c, obs[0]); end
      step(1'b0, 32'h0, 1'b1);
    end
    step(1'b1, 32'h81, 1'b1);
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== exp_out(pos[i], wid[i], word[i])) begin errors++; $display("FAIL rstmid w=%0d c=%0d got %b exp %b", wid[i], c, obs[i], exp_out(pos[i], wid[i], word[i])); end
      end
      checks++;
      if (if8.x_out !== seq[11-c]) begin errors++; $display("FAIL rstmid_x c=%0d got %b exp %b", c, if8.x_out, seq[11-c]); end
      step(1'b0, 32'h0, 1'b1);
    end
  endtask

  task automatic test_loopback();
    int hits;
    logic z;
    hits = 0;
    drain();
    step(1'b1, 32'h0, 1'b1);
    for (int c = 0; c < 10; c++) begin
      z = det == 3'b101;
      checks++;
      if (z !== (pos[1] == 4)) begin errors++; $display("FAIL loopback c=%0d got %b exp %b", c, z, pos[1] == 4); end
      hits += int'(z);
      step(1'b0, 32'h0, 1'b1);
    end
    checks++;
    if (hits != 1) begin errors++; $display("FAIL loopback_hits got %0d exp 1", hits); end
  endtask

  task automatic test_width2();
    logic [5:0] seq;
    seq = 6'b101100;
    drain();
    step(1'b1, 32'h2, 1'b1);
    for (int c = 0; c < 6; c++) begin
      checks++;
      if ({if2.x_out, if2.done} !== {seq[5-c], c == 5}) begin errors++; $display("FAIL w2 c=%0d got %b exp %b", c, {if2.x_out, if2.done}, {seq[5-c], c == 5}); end
      step(1'b0, 32'h0, 1'b1);
    end
    checks++;
    if (obs[2] !== 4'b1000) begin errors++; $display("FAIL w2_idle got %b exp 1000", obs[2]); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      step($urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 60) != 0);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== exp_out(pos[i], wid[i], word[i])) begin errors++; $display("FAIL random w=%0d c=%0d got %b exp %b", wid[i], c, obs[i], exp_out(pos[i], wid[i], word[i])); end
      end
    end
  endtask

  initial begin
    load = 1'b0;
    din = '0;
    reset_n = 1'b0;
    test_reset();
    test_a5();
    test_back_to_back();
    test_ignore_busy_load();
    test_reset_mid_frame();
    test_loopback();
    test_width2();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
